// File: rtl/axis_pkt_checker.sv
// axis_pkt_checker: AXI-Stream packet checker for incrementing data, keep shape, tuser and packet length.
// Define AXIS_PKT_CHECKER_ERR_CAPTURE_EN to add err_beat_idx/err_data_lo first-error capture outputs.
module axis_pkt_checker #(
    parameter int G_AXIS_DATA_WIDTH = 512,
    parameter int G_MAX_BEATS       = 64,
    parameter int G_CNT_WIDTH       = 32
) (
    input  logic                           s_axis_aclk,
    input  logic                           s_axis_aresetn,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [G_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [G_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tuser,
    input  logic                           hold_i,
    input  logic                           clear_i,
    output logic [G_CNT_WIDTH-1:0]         pkt_count,
    output logic [G_CNT_WIDTH-1:0]         beat_count,
    output logic [G_CNT_WIDTH-1:0]         err_count,
    output logic                           err_sticky,
    output logic [2:0]                     last_err_code
`ifdef AXIS_PKT_CHECKER_ERR_CAPTURE_EN
    ,
    output logic [15:0]                    err_beat_idx,
    output logic [63:0]                    err_data_lo
`endif
);
    localparam int KW = G_AXIS_DATA_WIDTH / 8;
    typedef logic [G_AXIS_DATA_WIDTH-1:0] data_t;
    typedef logic [KW-1:0] keep_t;
    typedef logic [G_CNT_WIDTH-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, BODY, SKIP} state_t;

    state_t      state_q, state_d;
    data_t       exp_q, exp_d;
    logic [15:0] idx_q, idx_d;
    cnt_t        pkt_q, pkt_d, beat_q, beat_d, errc_q, errc_d;
    logic        sticky_q, sticky_d, tready_q;
    logic [2:0]  code_q, code_d, code;
    logic        accept, keep_ok, err;

    function automatic cnt_t sat_inc(input cnt_t v);
        return &v ? v : v + cnt_t'(1);
    endfunction

    assign accept  = s_axis_tvalid && tready_q;
    // last beat keep must be 2^n-1 with n>0: nonzero and keep & (keep+1) == 0
    assign keep_ok = s_axis_tlast ? (s_axis_tkeep != '0 && (s_axis_tkeep & (s_axis_tkeep + keep_t'(1))) == '0)
                                  : &s_axis_tkeep;
    assign code    = state_q == SKIP                ? 3'd0 :
                     idx_q == 16'(G_MAX_BEATS)      ? 3'd4 :
                     s_axis_tdata != exp_q          ? 3'd1 :
                     !keep_ok                       ? 3'd2 :
                     s_axis_tuser                   ? 3'd3 : 3'd0;
    assign err     = accept && code != 3'd0;

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        pkt_d    = pkt_q;
        beat_d   = beat_q;
        errc_d   = errc_q;
        sticky_d = sticky_q;
        code_d   = code_q;
        if (accept) begin
            state_d = s_axis_tlast ? IDLE : (state_q == SKIP || err) ? SKIP : BODY;
            exp_d   = state_d == BODY ? exp_q + data_t'(1) : '0;
            idx_d   = state_d == BODY ? idx_q + 16'd1 : '0;
        end
        if (clear_i) begin
            pkt_d    = '0;
            beat_d   = '0;
            errc_d   = '0;
            sticky_d = 1'b0;
            code_d   = 3'd0;
        end else if (accept) begin
            beat_d = sat_inc(beat_q);
            if (err) begin
                errc_d   = sat_inc(errc_q);
                sticky_d = 1'b1;
                code_d   = code;
            end else if (s_axis_tlast && state_q != SKIP) begin
                pkt_d = sat_inc(pkt_q);
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            idx_q    <= '0;
            pkt_q    <= '0;
            beat_q   <= '0;
            errc_q   <= '0;
            sticky_q <= 1'b0;
            code_q   <= 3'd0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            idx_q    <= idx_d;
            pkt_q    <= pkt_d;
            beat_q   <= beat_d;
            errc_q   <= errc_d;
            sticky_q <= sticky_d;
            code_q   <= code_d;
            tready_q <= !hold_i;
        end
    end

    assign s_axis_tready = tready_q;
    assign pkt_count     = pkt_q;
    assign beat_count    = beat_q;
    assign err_count     = errc_q;
    assign err_sticky    = sticky_q;
    assign last_err_code = code_q;

`ifdef AXIS_PKT_CHECKER_ERR_CAPTURE_EN
    logic        cap_q, cap_d;
    logic [15:0] cidx_q, cidx_d;
    logic [63:0] cdat_q, cdat_d;

    always_comb begin
        cap_d  = cap_q;
        cidx_d = cidx_q;
        cdat_d = cdat_q;
        if (clear_i) begin
            cap_d  = 1'b0;
            cidx_d = '0;
            cdat_d = '0;
        end else if (err && !cap_q) begin
            cap_d  = 1'b1;
            cidx_d = idx_q;
            cdat_d = s_axis_tdata[63:0];
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            cap_q  <= 1'b0;
            cidx_q <= '0;
            cdat_q <= '0;
        end else begin
            cap_q  <= cap_d;
            cidx_q <= cidx_d;
            cdat_q <= cdat_d;
        end
    end

    assign err_beat_idx = cidx_q;
    assign err_data_lo  = cdat_q;
`endif
endmodule
